word_merge_sched: RTL and testbench

Round-robin scheduler that lets up to N requesters fill the high and low byte fields of one shared 16-bit packed word ({high[7:0], low[7:0]}) and emits the completed word through a valid/ready handshake. It sits between field-producing agents and any consumer of packed word values, and it serialises all writes to the shared word register. Missing fields are filled with a default byte when a partial word is flushed.

---
 rtl/word_merge_sched.sv | 148 ++++++++++++++
 tb/tb_word_merge_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/word_merge_sched.sv
// Round-robin merge of per-requester byte fields into one packed word.
// Optional partial-word flush enabled by defining WORD_MERGE_FLUSH_EN.
module word_merge_sched #(
    parameter int          N            = 4,
    parameter logic [7:0]  DEFAULT_BYTE = 8'h0D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [2*N-1:0]    req_mask,
    input  logic [16*N-1:0]   req_data,
    output logic [N-1:0]      gnt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_word
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

`ifdef WORD_MERGE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef enum logic {FILL, EMIT} state_t;

    state_t         state_q, state_d;
    logic [15:0]    word_q, word_d;
    logic [1:0]     fill_q, fill_d;
    logic [PW-1:0]  rr_q, rr_d;
    logic [15:0]    out_word_d;
    logic           out_valid_d;

    logic [N-1:0]   elig;
    logic           hit;
    int             gidx;
    logic [1:0]     sel_mask;
    logic [15:0]    sel_data;
    logic [15:0]    mrg_word, emit_word;
    logic [1:0]     mrg_fill;
    logic           flush_act;

    assign flush_act = FLUSH_EN & flush;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i]
                && (req_mask[2*i +: 2] != 2'b00)
                && ((req_mask[2*i +: 2] & fill_q) == 2'b00);
        end
    end

    // scan upward from rr_q with wrap; first eligible wins
    always_comb begin
        int idx;
        hit  = 1'b0;
        gidx = 0;
        idx  = 0;
        if (state_q == FILL) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= N) idx = idx - N;
                for (int i = 0; i < N; i++) begin
                    if (!hit && (i == idx) && elig[i]) begin
                        hit  = 1'b1;
                        gidx = i;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        sel_mask = 2'b00;
        sel_data = 16'h0000;
        for (int i = 0; i < N; i++) begin
            gnt[i] = hit && (gidx == i);
            if (gnt[i]) begin
                sel_mask = req_mask[2*i +: 2];
                sel_data = req_data[16*i +: 16];
            end
        end
    end

    always_comb begin
        mrg_word = word_q;
        mrg_fill = fill_q | sel_mask;
        if (sel_mask[1]) mrg_word[15:8] = sel_data[15:8];
        if (sel_mask[0]) mrg_word[7:0]  = sel_data[7:0];
        emit_word = {mrg_fill[1] ? mrg_word[15:8] : DEFAULT_BYTE,
                     mrg_fill[0] ? mrg_word[7:0]  : DEFAULT_BYTE};
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        fill_d      = fill_q;
        rr_d        = rr_q;
        out_word_d  = out_word;
        out_valid_d = out_valid;
        unique case (state_q)
            FILL: begin
                word_d = mrg_word;
                fill_d = mrg_fill;
                if (hit) begin
                    rr_d = (gidx == N-1) ? '0 : PW'(gidx + 1);
                end
                if ((mrg_fill == 2'b11)
                    || (flush_act && (mrg_fill != 2'b00))) begin
                    state_d     = EMIT;
                    out_word_d  = emit_word;
                    out_valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    fill_d      = 2'b00;
                    word_d      = 16'h0000;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            word_q    <= 16'h0000;
            fill_q    <= 2'b00;
            rr_q      <= '0;
            out_word  <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            fill_q    <= fill_d;
            rr_q      <= rr_d;
            out_word  <= out_word_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_word_merge_sched.sv
// Directed bench for word_merge_sched (N=4); follows WORD_MERGE_FLUSH_EN.
module tb_word_merge_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  req_mask;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;

    int nvec = 0;
    int nerr = 0;

    word_merge_sched #(.N(4), .DEFAULT_BYTE(8'h0D)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mask(req_mask),
        .req_data(req_data), .gnt(gnt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setr(input int i, input logic r, input logic [1:0] m,
                        input logic [15:0] d);
        req[i]           = r;
        req_mask[2*i +: 2]  = m;
        req_data[16*i +: 16] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_mask = '0; req_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_word", out_word, 16'h0000);
        chk("rst_gnt", {12'd0, gnt}, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // single full writer
        tick();
        setr(0, 1'b1, 2'b11, 16'h0203);
        #1 chk("t1_gnt", {12'd0, gnt}, 16'h0001);
        tick();
        setr(0, 1'b0, 2'b00, 16'h0000);
        #1 chk("t1_valid", {15'd0, out_valid}, 16'h0001);
        chk("t1_word", out_word, 16'h0203);
        chk("t1_emit_gnt", {12'd0, gnt}, 16'h0000);
        tick();
        #1 chk("t1_drop", {15'd0, out_valid}, 16'h0000);

        // two single-byte writers
        setr(1, 1'b1, 2'b01, 16'h7706);
        setr(2, 1'b1, 2'b10, 16'h0588);
        #1 chk("t2_gnt1", {12'd0, gnt}, 16'h0002);
        tick();
        setr(1, 1'b0, 2'b00, 16'h0000);
        #1 chk("t2_gnt2", {12'd0, gnt}, 16'h0004);
        tick();
        setr(2, 1'b0, 2'b00, 16'h0000);
        #1 chk("t2_valid", {15'd0, out_valid}, 16'h0001);
        chk("t2_word", out_word, 16'h0506);
        tick();
        setr(3, 1'b1, 2'b11, 16'h1234);
        #1 chk("t2_rr3", {12'd0, gnt}, 16'h0008);
        tick();
        setr(3, 1'b0, 2'b00, 16'h0000);
        #1 chk("t2_word3", out_word, 16'h1234);
        tick();

        // overlap blocking
        setr(0, 1'b1, 2'b10, 16'h1199);
        setr(3, 1'b1, 2'b10, 16'h3333);
        setr(1, 1'b1, 2'b01, 16'h4422);
        #1 chk("t3_gnt0", {12'd0, gnt}, 16'h0001);
        tick();
        setr(0, 1'b0, 2'b00, 16'h0000);
        #1 chk("t3_gnt1", {12'd0, gnt}, 16'h0002);
        tick();
        setr(1, 1'b0, 2'b00, 16'h0000);
        #1 chk("t3_valid", {15'd0, out_valid}, 16'h0001);
        chk("t3_word", out_word, 16'h1122);
        chk("t3_emit_gnt", {12'd0, gnt}, 16'h0000);
        tick();
        #1 chk("t3_gnt3", {12'd0, gnt}, 16'h0008);
        tick();
        setr(3, 1'b0, 2'b00, 16'h0000);
        setr(0, 1'b1, 2'b01, 16'h0055);
        out_ready = 1'b0;
        #1 chk("t5_gnt0", {12'd0, gnt}, 16'h0001);

        // backpressure with all requesters pending
        tick();
        setr(0, 1'b1, 2'b11, 16'hA0A1);
        setr(1, 1'b1, 2'b11, 16'hB0B1);
        setr(2, 1'b1, 2'b11, 16'hC0C1);
        setr(3, 1'b1, 2'b11, 16'hD0D1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t5_hold_gnt", {12'd0, gnt}, 16'h0000);
            chk("t5_hold_word", out_word, 16'h3355);
            chk("t5_hold_valid", {15'd0, out_valid}, 16'h0001);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("t5_acc_gnt", {12'd0, gnt}, 16'h0000);
        tick();
        #1 chk("t5_resume", {12'd0, gnt}, 16'h0002);
        tick();
        req = '0;
        #1 chk("t5_word", out_word, 16'hB0B1);
        tick();

        // flush with a partial word
        setr(2, 1'b1, 2'b10, 16'hAA00);
        flush = 1'b1;
        #1 chk("t4_gnt", {12'd0, gnt}, 16'h0004);
        tick();
        setr(2, 1'b0, 2'b00, 16'h0000);
        flush = 1'b0;
`ifdef WORD_MERGE_FLUSH_EN
        #1 chk("t4_valid", {15'd0, out_valid}, 16'h0001);
        chk("t4_word", out_word, 16'hAA0D);
`else
        #1 chk("t4_noemit", {15'd0, out_valid}, 16'h0000);
`endif
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("t4_empty_flush", {15'd0, out_valid}, 16'h0000);
`ifndef WORD_MERGE_FLUSH_EN
        setr(0, 1'b1, 2'b01, 16'h0077);
        #1 chk("t4_fill_gnt", {12'd0, gnt}, 16'h0001);
        tick();
        setr(0, 1'b0, 2'b00, 16'h0000);
        #1 chk("t4_full_word", out_word, 16'hAA77);
        chk("t4_full_valid", {15'd0, out_valid}, 16'h0001);
        tick();
`endif

        // reset while a word is pending
        setr(1, 1'b1, 2'b11, 16'h6162);
        out_ready = 1'b0;
        #1 chk("t6_gnt", {12'd0, gnt}, 16'h0002);
        tick();
        setr(1, 1'b0, 2'b00, 16'h0000);
        #1 chk("t6_word", out_word, 16'h6162);
        rst_n = 1'b0;
        #1 chk("t6_rst_valid", {15'd0, out_valid}, 16'h0000);
        chk("t6_rst_word", out_word, 16'h0000);
        rst_n = 1'b1;
        #1;
        setr(0, 1'b1, 2'b11, 16'h0101);
        setr(1, 1'b1, 2'b11, 16'h0202);
        setr(2, 1'b1, 2'b11, 16'h0303);
        #1 chk("t6_gnt0", {12'd0, gnt}, 16'h0001);
        out_ready = 1'b1;
        tick();
        req = '0;
        #1 chk("t6_word0", out_word, 16'h0101);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
